stream_master_router: RTL and testbench

//  Per-master ingress of the stream crossbar: decodes s_tdest_i of each packet, raises a one-hot request

---
 rtl/stream_master_router_pkg.sv | 18 +
 rtl/stream_master_router_if.sv | 38 +++
 rtl/stream_master_router_skid.sv | 55 +++++
 rtl/stream_master_router.sv | 152 +++++++++++++++
 tb/tb_stream_master_router.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stream_master_router_pkg.sv
// Shared types and constants for the stream crossbar ingress router.
package stream_xbar_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    XFER,
    DROP
  } router_state_e;

  localparam int SKID_DEPTH     = 2;
  localparam int DROP_CNT_WIDTH = 16;

  function automatic int dest_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stream_master_router_if.sv
// Ingress stream, egress stream and arbiter request/grant of one router.
interface stream_master_router_if
  import stream_xbar_pkg::*;
#(
  parameter int M_DATA_COUNT = 3,
  parameter int T_DATA_WIDTH = 32
);

  localparam int T_DEST_WIDTH = dest_width(M_DATA_COUNT);

  logic                    s_tvalid_i;
  logic                    s_tready_o;
  logic [T_DATA_WIDTH-1:0] s_tdata_i;
  logic                    s_tlast_i;
  logic [T_DEST_WIDTH-1:0] s_tdest_i;
  logic [M_DATA_COUNT-1:0] req_o;
  logic [M_DATA_COUNT-1:0] grant_i;
  logic                    m_tvalid_o;
  logic                    m_tready_i;
  logic [T_DATA_WIDTH-1:0] m_tdata_o;
  logic                    m_tlast_o;
  logic [T_DEST_WIDTH-1:0] m_tdest_o;

  modport master (
    output s_tvalid_i, s_tdata_i, s_tlast_i, s_tdest_i,
    output grant_i, m_tready_i,
    input  s_tready_o, req_o, m_tvalid_o,
    input  m_tdata_o, m_tlast_o, m_tdest_o
  );

  modport slave (
    input  s_tvalid_i, s_tdata_i, s_tlast_i, s_tdest_i,
    input  grant_i, m_tready_i,
    output s_tready_o, req_o, m_tvalid_o,
    output m_tdata_o, m_tlast_o, m_tdest_o
  );

endinterface

// File: rtl/stream_master_router_skid.sv
// Two-entry skid buffer: registered output, full throughput,
// ready towards ingress depends only on the occupancy register.
module stream_skid_buffer
  import stream_xbar_pkg::*;
#(
  parameter int WIDTH = 33
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam int PW = $clog2(SKID_DEPTH);

  logic [WIDTH-1:0] mem_q [SKID_DEPTH];
  logic [PW-1:0]    wr_q;
  logic [PW-1:0]    rd_q;
  logic [PW:0]      cnt_q;
  logic             push;
  logic             pop;

  assign in_ready  = cnt_q < (PW+1)'(SKID_DEPTH);
  assign out_valid = cnt_q != '0;
  assign out_data  = mem_q[rd_q];
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < SKID_DEPTH; i++)
        mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= in_data;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop)
        rd_q <= rd_q + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/stream_master_router.sv
// Per-master crossbar ingress: dest decode, request/grant, skid forward.
// STREAM_ROUTER_DROP_CNT_EN adds drop_cnt_o, a saturating drop counter.
module stream_master_router
  import stream_xbar_pkg::*;
#(
  parameter int S_DATA_COUNT = 2,
  parameter int M_DATA_COUNT = 3,
  parameter int T_DATA_WIDTH = 32,
  parameter int MASTER_ID    = 0
) (
  input  logic clk_i,
  input  logic rst_i,
`ifdef STREAM_ROUTER_DROP_CNT_EN
  output logic [DROP_CNT_WIDTH-1:0] drop_cnt_o,
`endif
  stream_master_router_if.slave bus
);

  localparam int T_DEST_WIDTH = dest_width(M_DATA_COUNT);

  if (MASTER_ID < 0 || MASTER_ID >= S_DATA_COUNT) begin : g_bad_id
    $error("MASTER_ID outside 0..S_DATA_COUNT-1");
  end

  router_state_e           state_q, state_d;
  logic [T_DEST_WIDTH-1:0] dest_q, dest_d;
  logic [M_DATA_COUNT-1:0] req_q, req_d;
  logic [M_DATA_COUNT-1:0] req_sel;
  logic                    in_done_q, in_done_d;
  logic                    in_range;
  logic                    grant_cur;

  logic                    skid_in_valid;
  logic                    skid_in_ready;
  logic                    skid_out_valid;
  logic                    skid_out_ready;
  logic [T_DATA_WIDTH:0]   skid_out;
  logic                    skid_last;
  logic                    m_valid;
  logic                    s_ready;

  assign in_range  = int'(bus.s_tdest_i) < M_DATA_COUNT;
  assign grant_cur = bus.grant_i[dest_q];
  assign skid_last = skid_out[T_DATA_WIDTH];

  always_comb begin
    req_sel = '0;
    for (int i = 0; i < M_DATA_COUNT; i++)
      req_sel[i] = int'(bus.s_tdest_i) == i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      dest_q    <= '0;
      req_q     <= '0;
      in_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dest_q    <= dest_d;
      req_q     <= req_d;
      in_done_q <= in_done_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    dest_d         = dest_q;
    req_d          = req_q;
    in_done_d      = in_done_q;
    s_ready        = 1'b0;
    skid_in_valid  = 1'b0;
    skid_out_ready = 1'b0;
    m_valid        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.s_tvalid_i) begin
          if (in_range) begin
            dest_d    = bus.s_tdest_i;
            req_d     = req_sel;
            in_done_d = 1'b0;
            state_d   = REQ;
          end else begin
            state_d   = DROP;
          end
        end
      end
      REQ: begin
        if (grant_cur)
          state_d = XFER;
      end
      XFER: begin
        // ingress closes once the last beat is in the buffer
        s_ready        = skid_in_ready & ~in_done_q;
        skid_in_valid  = bus.s_tvalid_i & ~in_done_q;
        m_valid        = skid_out_valid & grant_cur;
        skid_out_ready = bus.m_tready_i & grant_cur;
        if (bus.s_tvalid_i & s_ready & bus.s_tlast_i)
          in_done_d = 1'b1;
        if (m_valid & bus.m_tready_i & skid_last) begin
          state_d   = IDLE;
          req_d     = '0;
          in_done_d = 1'b0;
        end
      end
      DROP: begin
        s_ready = 1'b1;
        if (bus.s_tvalid_i & bus.s_tlast_i)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  stream_skid_buffer #(
    .WIDTH (T_DATA_WIDTH + 1)
  ) u_skid (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .in_valid  (skid_in_valid),
    .in_ready  (skid_in_ready),
    .in_data   ({bus.s_tlast_i, bus.s_tdata_i}),
    .out_valid (skid_out_valid),
    .out_ready (skid_out_ready),
    .out_data  (skid_out)
  );

  assign bus.s_tready_o = s_ready;
  assign bus.req_o      = req_q;
  assign bus.m_tvalid_o = m_valid;
  assign bus.m_tdata_o  = skid_out[T_DATA_WIDTH-1:0];
  // last feeds the arbiter, so never show a stale head flag
  assign bus.m_tlast_o  = m_valid & skid_last;
  assign bus.m_tdest_o  = dest_q;

`ifdef STREAM_ROUTER_DROP_CNT_EN
  logic                      drop_enter;
  logic [DROP_CNT_WIDTH-1:0] drop_cnt_q;

  assign drop_enter = (state_q == IDLE) & bus.s_tvalid_i & ~in_range;

  always_ff @(posedge clk_i) begin
    if (rst_i)
      drop_cnt_q <= '0;
    else if (drop_enter && drop_cnt_q != '1)
      drop_cnt_q <= drop_cnt_q + 1'b1;
  end

  assign drop_cnt_o = drop_cnt_q;
`endif

endmodule

// File: tb/tb_stream_master_router.sv
// Directed bench for stream_master_router (M_DATA_COUNT=3, 32-bit data).
module tb_stream_master_router;
  import stream_xbar_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  stream_master_router_if #(
    .M_DATA_COUNT (3),
    .T_DATA_WIDTH (32)
  ) bus ();

`ifdef STREAM_ROUTER_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  stream_master_router #(
    .S_DATA_COUNT (2),
    .M_DATA_COUNT (3),
    .T_DATA_WIDTH (32),
    .MASTER_ID    (0)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
`ifdef STREAM_ROUTER_DROP_CNT_EN
    .drop_cnt_o (drop_cnt),
`endif
    .bus        (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] d,
                       input logic l, input logic [1:0] dst);
    bus.s_tvalid_i = v;
    bus.s_tdata_i  = d;
    bus.s_tlast_i  = l;
    bus.s_tdest_i  = dst;
  endtask

  // m_tready 0101.. from first XFER cycle
  int din3 [10] = '{0, 1, 2, 3, 3, 4, 4, -1, -1, -1};
  int rdy3 [10] = '{1, 1, 1, 0, 1, 0, 1, 0, 0, 0};
  int vld3 [10] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1};
  int out3 [10] = '{-1, 0, 1, 1, 2, 2, 3, 3, 4, 4};
  // grant drops for three cycles mid-packet
  int g5   [8]  = '{1, 1, 0, 0, 0, 1, 1, 1};
  int din5 [8]  = '{0, 1, 2, 3, 3, 3, 3, -1};
  int rdy5 [8]  = '{1, 1, 1, 0, 0, 0, 1, 0};
  int vld5 [8]  = '{0, 1, 0, 0, 0, 1, 1, 1};
  int out5 [8]  = '{-1, 0, 1, 1, 1, 1, 2, 3};

  initial begin
    drive(1'b0, 32'h0, 1'b0, 2'd0);
    bus.grant_i    = 3'b000;
    bus.m_tready_i = 1'b0;

    // reset
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_s_tready", bus.s_tready_o, 0);
    chk("rst_req", bus.req_o, 0);
    chk("rst_m_tvalid", bus.m_tvalid_o, 0);
    chk("rst_m_tdata", bus.m_tdata_o, 0);
    chk("rst_m_tlast", bus.m_tlast_o, 0);
    chk("rst_m_tdest", bus.m_tdest_o, 0);

    // 4-beat packet to dest 1, grant two cycles after req
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 32'hD000_0000, 1'b0, 2'd1);
    bus.m_tready_i = 1'b1;
    #1;
    chk("t1_idle_rdy", bus.s_tready_o, 0);
    chk("t1_idle_req", bus.req_o, 0);
    @(negedge clk);
    #1;
    chk("t1_req", bus.req_o, 3'b010);
    @(negedge clk);
    bus.grant_i = 3'b101;
    #1;
    chk("t1_req_other_grant", bus.req_o, 3'b010);
    chk("t1_req_rdy", bus.s_tready_o, 0);
    @(negedge clk);
    bus.grant_i = 3'b010;
    #1;
    chk("t1_grant_rdy", bus.s_tready_o, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i < 4)
        drive(1'b1, 32'hD000_0000 + i, i == 3, 2'd1);
      else
        bus.s_tvalid_i = 1'b0;
      #1;
      chk("t1_req_hold", bus.req_o, 3'b010);
      chk("t1_s_tready", bus.s_tready_o, i < 4);
      chk("t1_m_tvalid", bus.m_tvalid_o, i > 0);
      if (i > 0) begin
        chk("t1_m_tdata", bus.m_tdata_o, 32'hD000_0000 + i - 1);
        chk("t1_m_tlast", bus.m_tlast_o, i == 4);
        chk("t1_m_tdest", bus.m_tdest_o, 1);
      end
    end
    @(negedge clk);
    bus.grant_i = 3'b000;
    #1;
    chk("t1_req_off", bus.req_o, 0);
    chk("t1_vld_off", bus.m_tvalid_o, 0);

    // out-of-range dest 3: three beats swallowed
    @(negedge clk);
    drive(1'b1, 32'h5A, 1'b0, 2'd3);
    #1;
    chk("t2_idle_rdy", bus.s_tready_o, 0);
    @(negedge clk);
    #1;
    chk("t2_rdy0", bus.s_tready_o, 1);
    chk("t2_req0", bus.req_o, 0);
    chk("t2_vld0", bus.m_tvalid_o, 0);
    @(negedge clk);
    drive(1'b1, 32'h5B, 1'b0, 2'd3);
    #1;
    chk("t2_rdy1", bus.s_tready_o, 1);
    @(negedge clk);
    drive(1'b1, 32'h5C, 1'b1, 2'd3);
    #1;
    chk("t2_rdy2", bus.s_tready_o, 1);
    chk("t2_vld2", bus.m_tvalid_o, 0);
    chk("t2_req2", bus.req_o, 0);
    @(negedge clk);
    bus.s_tvalid_i = 1'b0;
    #1;
    chk("t2_done_rdy", bus.s_tready_o, 0);
    chk("t2_dest_kept", bus.m_tdest_o, 1);
`ifdef STREAM_ROUTER_DROP_CNT_EN
    chk("t2_drop_cnt", drop_cnt, 1);
`endif

    // back-to-back single-beat packets, dest 0 then 2
    @(negedge clk);
    drive(1'b1, 32'hA0, 1'b1, 2'd0);
    #1;
    chk("t4_idle_rdy", bus.s_tready_o, 0);
    @(negedge clk);
    bus.grant_i = 3'b001;
    #1;
    chk("t4_req_a", bus.req_o, 3'b001);
    chk("t4_dest_a", bus.m_tdest_o, 0);
    @(negedge clk);
    #1;
    chk("t4_rdy_a", bus.s_tready_o, 1);
    chk("t4_vld_a0", bus.m_tvalid_o, 0);
    @(negedge clk);
    drive(1'b1, 32'hB0, 1'b1, 2'd2);
    #1;
    chk("t4_rdy_closed", bus.s_tready_o, 0);
    chk("t4_vld_a", bus.m_tvalid_o, 1);
    chk("t4_data_a", bus.m_tdata_o, 32'hA0);
    chk("t4_last_a", bus.m_tlast_o, 1);
    chk("t4_dest_a_out", bus.m_tdest_o, 0);
    @(negedge clk);
    bus.grant_i = 3'b100;
    #1;
    chk("t4_req_gap", bus.req_o, 0);
    chk("t4_vld_gap", bus.m_tvalid_o, 0);
    @(negedge clk);
    #1;
    chk("t4_req_b", bus.req_o, 3'b100);
    chk("t4_dest_b", bus.m_tdest_o, 2);
    @(negedge clk);
    #1;
    chk("t4_rdy_b", bus.s_tready_o, 1);
    @(negedge clk);
    bus.s_tvalid_i = 1'b0;
    #1;
    chk("t4_vld_b", bus.m_tvalid_o, 1);
    chk("t4_data_b", bus.m_tdata_o, 32'hB0);
    chk("t4_last_b", bus.m_tlast_o, 1);

    // 5-beat packet with m_tready toggling
    @(negedge clk);
    drive(1'b1, 32'hE000_0000, 1'b0, 2'd0);
    bus.grant_i    = 3'b001;
    bus.m_tready_i = 1'b0;
    #1;
    chk("t3_req_idle", bus.req_o, 0);
    @(negedge clk);
    #1;
    chk("t3_req", bus.req_o, 3'b001);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.m_tready_i = i[0];
      if (din3[i] >= 0)
        drive(1'b1, 32'hE000_0000 + din3[i], din3[i] == 4, 2'd0);
      else
        bus.s_tvalid_i = 1'b0;
      #1;
      chk("t3_s_tready", bus.s_tready_o, rdy3[i]);
      chk("t3_m_tvalid", bus.m_tvalid_o, vld3[i]);
      if (out3[i] >= 0) begin
        chk("t3_m_tdata", bus.m_tdata_o, 32'hE000_0000 + out3[i]);
        chk("t3_m_tlast", bus.m_tlast_o, out3[i] == 4);
      end
    end

    // grant lost for three cycles mid-packet
    @(negedge clk);
    drive(1'b1, 32'hF000_0000, 1'b0, 2'd1);
    bus.grant_i    = 3'b010;
    bus.m_tready_i = 1'b1;
    #1;
    chk("t5_req_idle", bus.req_o, 0);
    chk("t5_vld_idle", bus.m_tvalid_o, 0);
    @(negedge clk);
    #1;
    chk("t5_req", bus.req_o, 3'b010);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.grant_i = (g5[i] != 0) ? 3'b010 : 3'b000;
      if (din5[i] >= 0)
        drive(1'b1, 32'hF000_0000 + din5[i], din5[i] == 3, 2'd1);
      else
        bus.s_tvalid_i = 1'b0;
      #1;
      chk("t5_req_hold", bus.req_o, 3'b010);
      chk("t5_s_tready", bus.s_tready_o, rdy5[i]);
      chk("t5_m_tvalid", bus.m_tvalid_o, vld5[i]);
      if (out5[i] >= 0) begin
        chk("t5_m_tdata", bus.m_tdata_o, 32'hF000_0000 + out5[i]);
        chk("t5_m_tlast", bus.m_tlast_o, vld5[i] == 1 && out5[i] == 3);
      end
    end

    // reset while XFER holds a full buffer
    @(negedge clk);
    drive(1'b1, 32'hC0, 1'b0, 2'd2);
    bus.grant_i    = 3'b100;
    bus.m_tready_i = 1'b0;
    #1;
    chk("t6_req_idle", bus.req_o, 0);
    @(negedge clk);
    #1;
    chk("t6_req", bus.req_o, 3'b100);
    @(negedge clk);
    #1;
    chk("t6_rdy0", bus.s_tready_o, 1);
    @(negedge clk);
    drive(1'b1, 32'hC1, 1'b0, 2'd2);
    #1;
    chk("t6_rdy1", bus.s_tready_o, 1);
    chk("t6_vld1", bus.m_tvalid_o, 1);
    chk("t6_data1", bus.m_tdata_o, 32'hC0);
    @(negedge clk);
    drive(1'b1, 32'hC2, 1'b0, 2'd2);
    #1;
    chk("t6_full_rdy", bus.s_tready_o, 0);
    chk("t6_full_vld", bus.m_tvalid_o, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 32'hE1, 1'b1, 2'd0);
    bus.grant_i    = 3'b001;
    bus.m_tready_i = 1'b1;
    #1;
    chk("t6_req_rst", bus.req_o, 0);
    chk("t6_vld_rst", bus.m_tvalid_o, 0);
    chk("t6_rdy_rst", bus.s_tready_o, 0);
    chk("t6_last_rst", bus.m_tlast_o, 0);
    chk("t6_dest_rst", bus.m_tdest_o, 0);
    chk("t6_data_rst", bus.m_tdata_o, 0);
    chk("t6_state_rst", 32'(dut.state_q), 32'(IDLE));
`ifdef STREAM_ROUTER_DROP_CNT_EN
    chk("t6_drop_cnt_rst", drop_cnt, 0);
`endif
    @(negedge clk);
    #1;
    chk("t6_req_new", bus.req_o, 3'b001);
    @(negedge clk);
    #1;
    chk("t6_rdy_new", bus.s_tready_o, 1);
    @(negedge clk);
    bus.s_tvalid_i = 1'b0;
    #1;
    chk("t6_vld_new", bus.m_tvalid_o, 1);
    chk("t6_data_new", bus.m_tdata_o, 32'hE1);
    chk("t6_last_new", bus.m_tlast_o, 1);
    @(negedge clk);
    #1;
    chk("t6_req_end", bus.req_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
